// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared state encoding and slice width for the nibble-serial adder
package nsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nsa_state_e;

   localparam int NIB_W = 4;

endpackage

// File: rtl/nsa_add4.sv
// rtl/nsa_add4.sv - combinational 4-bit ripple-carry slice built from full-adder cells
module nsa_add4
   import nsa_pkg::*;
(
   input  logic [NIB_W-1:0] a4,
   input  logic [NIB_W-1:0] b4,
   input  logic             ci,
   output logic [NIB_W-1:0] s4,
   output logic             co
);

   logic [NIB_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < NIB_W; i++) begin : g_fa
      assign s4[i]  = a4[i] ^ b4[i] ^ c[i];
      assign c[i+1] = (a4[i] & b4[i]) | (a4[i] & c[i]) | (b4[i] & c[i]);
   end

   assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit add sequenced over one shared 4-bit slice, LSB nibble first
// Optional signed-overflow output enabled by NSA_SIGNED_OVF_EN.
module nibble_serial_add_ctrl
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef NSA_SIGNED_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NIB - 1);

   nsa_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [NIB_W-1:0] slice_s;
   logic             slice_c;

   // Operands shift right each RUN cycle so the active nibble is always at [3:0].
   nsa_add4 u_add4 (
      .a4 (a_q[NIB_W-1:0]),
      .b4 (b_q[NIB_W-1:0]),
      .ci (carry_q),
      .s4 (slice_s),
      .co (slice_c)
   );

`ifdef NSA_SIGNED_OVF_EN
   logic ovf_q, ovf_d;
   logic ovf_calc;

   // Same-sign operands giving an opposite-sign result is carry-into-MSB XOR carry-out.
   assign ovf_calc = (a_q[NIB_W-1] ~^ b_q[NIB_W-1]) & (slice_s[NIB_W-1] ^ a_q[NIB_W-1]);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef NSA_SIGNED_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef NSA_SIGNED_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
`ifdef NSA_SIGNED_OVF_EN
      ovf_d     = ovf_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            carry_d = slice_c;
            a_d     = a_q >> NIB_W;
            b_d     = b_q >> NIB_W;
            for (int n = 0; n < NIB; n++) begin
               if (cnt_q == CNT_W'(n)) begin
                  sum_d[n*NIB_W +: NIB_W] = slice_s;
               end
            end
            if (cnt_q == LAST_K) begin
               cout_d  = slice_c;
`ifdef NSA_SIGNED_OVF_EN
               ovf_d   = ovf_calc;
`endif
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef NSA_SIGNED_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - randomized self-checking bench for nibble_serial_add_ctrl (WIDTH=16)
module tb_nibble_serial_add_ctrl;

   localparam int W   = 16;
   localparam int LAT = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
`ifdef NSA_SIGNED_OVF_EN
   logic         ovf;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef NSA_SIGNED_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain full-width arithmetic on the operands as presented.
   task automatic run_add(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci, input int hold);
      logic [W:0]   ref_full;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
      int           lat;
      ref_full = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci};
      exp_sum  = ref_full[W-1:0];
      exp_cout = ref_full[W];
      exp_ovf  = (ai[W-1] == bi[W-1]) && (exp_sum[W-1] != ai[W-1]);

      for (int i = 0; i < 20 && !in_ready; i++) tick();
      check_eq("in_ready_idle", in_ready, 1);
      a = ai; b = bi; cin = ci; in_valid = 1'b1;
      tick();
      check_eq("busy_run", busy, 1);
      check_eq("in_ready_run", in_ready, 0);
      // Scramble inputs; a latched design must not notice.
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);

      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      in_valid = 1'b0;
      check_eq("latency", lat, LAT);
      check_eq("sum", sum, exp_sum);
      check_eq("cout", cout, exp_cout);
`ifdef NSA_SIGNED_OVF_EN
      check_eq("ovf", ovf, exp_ovf);
`else
      if (exp_ovf) lat = lat;
`endif
      check_eq("busy_done", busy, 0);

      for (int h = 0; h < hold; h++) begin
         tick();
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_sum", sum, exp_sum);
         check_eq("hold_cout", cout, exp_cout);
         check_eq("hold_in_ready", in_ready, 0);
      end

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("post_valid", out_valid, 0);
      check_eq("post_in_ready", in_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      tick();
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_sum", sum, 0);
      check_eq("rst_cout", cout, 0);
      tick();
      rst = 1'b0;
      tick();

      run_add(16'h1234, 16'h4321, 1'b0, 0);
      run_add(16'hFFFF, 16'h0001, 1'b0, 0);
      run_add(16'hFFFF, 16'h0000, 1'b1, 0);
      run_add(16'h0000, 16'h0000, 1'b0, 0);
      run_add(16'hA5A5, 16'h5A5B, 1'b1, 10);
`ifdef NSA_SIGNED_OVF_EN
      run_add(16'h7FFF, 16'h0001, 1'b0, 1);
      run_add(16'h8000, 16'hFFFF, 1'b0, 1);
`endif

      // Abort an add two cycles after acceptance.
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_eq("abort_in_ready", in_ready, 1);
      check_eq("abort_out_valid", out_valid, 0);
      check_eq("abort_sum", sum, 0);
      check_eq("abort_busy", busy, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq("abort_no_valid", out_valid, 0);
      end
      run_add(16'h0F0F, 16'h00F1, 1'b0, 0);

      for (int t = 0; t < 30; t++) begin
         run_add(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
